// File: rtl/uart_tx_fifo.sv
// Single-clock UART transmitter with integrated baud divider, configurable frame format
// and a small TX FIFO; frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [2:0]       DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [7:0]       DATA_MASK  = 8'((1 << DATA_BITS) - 1);
    localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             uart_tx_q, uart_tx_d;
    logic             busy_q, busy_d;

    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push, pop, fifo_empty, tick;
    logic [7:0]       head_data;
    logic             head_parity;

    assign in_ready    = (count_q != FULL_LEVEL);
    assign push        = in_valid && in_ready;
    assign fifo_empty  = (count_q == '0);
    assign head_data   = fifo_mem_q[rd_ptr_q] & DATA_MASK;
    assign head_parity = (PARITY == 1) ? ~^head_data : ^head_data;
    assign tick        = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every process sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            uart_tx_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            uart_tx_q <= uart_tx_d;
            busy_q    <= busy_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        cnt_d    = '0;
        if (state_q != S_IDLE && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = head_data;
                    parity_d = head_parity;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // Chain straight into the next frame so the line never idles between queued bytes.
                        if (!fifo_empty) begin
                            pop      = 1'b1;
                            shift_d  = head_data;
                            parity_d = head_parity;
                            state_d  = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        uart_tx_d = 1'b1;
        case (state_q)
            S_START:  uart_tx_d = 1'b0;
            S_DATA:   uart_tx_d = shift_q[0];
            S_PARITY: uart_tx_d = parity_q;
            default:  uart_tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign uart_tx    = uart_tx_q;
    assign busy       = busy_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four frame formats (8N1, 8E1, 8O1, 7O2) at DIV=4,
// line waveforms compared against a frame model built from bit-level framing rules.
module tb_uart_tx_fifo;

    localparam int DIV  = 4;
    localparam int NDUT = 4;

    function automatic int db_of(input int g);
        return (g == 3) ? 7 : 8;
    endfunction

    function automatic int par_of(input int g);
        case (g)
            1:       return 2;
            2, 3:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NDUT-1:0] vld, rdy, tx, bsy;
    logic [7:0]      din;
    logic [2:0]      lvl [NDUT];

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] bq[$];
    logic       wave[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_fifo #(
            .CLK_HZ    (12_000_000),
            .BAUD      (3_000_000),
            .DATA_BITS (db_of(g)),
            .PARITY    (par_of(g)),
            .STOP_BITS (sb_of(g)),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[g]),
            .in_data   (din),
            .in_ready  (rdy[g]),
            .uart_tx   (tx[g]),
            .busy      (bsy[g]),
            .fifo_level(lvl[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bit k of 'bits' is the k-th bit on the line: start, data LSB first, optional parity, stops.
    task automatic frame_model(input int g, input logic [7:0] b, output logic [15:0] bits, output int nb);
        int ones;
        ones    = 0;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < db_of(g); i++) begin
            bits[1 + i] = b[i];
            ones += int'(b[i]);
        end
        nb = 1 + db_of(g) + sb_of(g);
        if (par_of(g) != 0) begin
            bits[1 + db_of(g)] = (par_of(g) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            nb++;
        end
    endtask

    function automatic logic wave_at(input int i);
        if (i < 0 || i >= wave.size()) return 1'bx;
        return wave[i];
    endfunction

    // Push one byte into an idle DUT and compare the whole line and busy waveforms.
    task automatic send_single(input int g, input logic [7:0] b, input string tag);
        logic [15:0] bits;
        int          nb, fl;
        logic [63:0] exp_tx, obs_tx, exp_bz, obs_bz;
        frame_model(g, b, bits, nb);
        fl     = nb * DIV;
        exp_tx = '0;
        exp_bz = '0;
        obs_tx = '0;
        obs_bz = '0;
        exp_tx[0] = 1'b1;
        for (int k = 0; k < fl; k++) begin
            exp_tx[1 + k] = bits[k / DIV];
            exp_bz[k]     = 1'b1;
        end
        exp_tx[fl + 1] = 1'b1;

        @(negedge clk);
        din    = b;
        vld[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[g] = 1'b0;
        check({tag, " level_after_push"}, 64'(lvl[g]), 64'd1);
        for (int k = 0; k < fl + 2; k++) begin
            @(negedge clk);
            obs_tx[k] = tx[g];
            obs_bz[k] = bsy[g];
            if (k == 0) check({tag, " level_after_pop"}, 64'(lvl[g]), 64'd0);
        end
        check({tag, " tx_wave"}, obs_tx, exp_tx);
        check({tag, " busy_wave"}, obs_bz, exp_bz);
    endtask

    // Stream every byte of bq into DUT 0 holding in_valid, then decode the captured 8N1 line.
    task automatic run_burst(input string tag);
        int n, idx, start, bad_rdy, max_lvl, mism, budget;
        logic acc;
        logic [15:0] bits;
        int nb;
        logic [7:0] got;
        n       = bq.size();
        idx     = 0;
        bad_rdy = 0;
        max_lvl = 0;
        mism    = 0;
        budget  = n * 40 + 20;
        wave.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            wave.push_back(tx[0]);
            if (rdy[0] !== (lvl[0] != 3'd4)) bad_rdy++;
            if (int'(lvl[0]) > max_lvl) max_lvl = int'(lvl[0]);
            acc = 1'b0;
            if (idx < n) begin
                din    = bq[idx];
                vld[0] = 1'b1;
                acc    = rdy[0];
            end else begin
                vld[0] = 1'b0;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        vld[0] = 1'b0;

        start = -1;
        for (int i = 0; i < wave.size() && start < 0; i++) begin
            if (wave[i] === 1'b0) start = i;
        end
        check({tag, " all_accepted"}, 64'(idx), 64'(n));
        check({tag, " ready_is_not_full"}, 64'(bad_rdy), 64'd0);
        check({tag, " peak_level"}, 64'(max_lvl), 64'd4);
        check({tag, " first_start_cycle"}, 64'(start), 64'd3);
        if (start < 0) start = 0;

        for (int f = 0; f < n; f++) begin
            frame_model(0, bq[f], bits, nb);
            for (int k = 0; k < nb * DIV; k++) begin
                if (wave_at(start + f * nb * DIV + k) !== bits[k / DIV]) mism++;
            end
            got = '0;
            for (int i = 0; i < 8; i++) got[i] = wave_at(start + f * 40 + (1 + i) * DIV + 2);
            check($sformatf("%s byte%0d", tag, f), 64'(got), 64'(bq[f]));
        end
        if (wave_at(start + n * 40) !== 1'b1) mism++;
        check({tag, " contiguous_wave_errors"}, 64'(mism), 64'd0);
        check({tag, " drained_level_busy"}, {60'd0, bsy[0], lvl[0]}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int quiet_bad;
        rst_n = 1'b0;
        vld   = '0;
        din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset_state dut%0d", g), 64'({tx[g], bsy[g], lvl[g], rdy[g]}), 64'(6'b1_0_000_1));
        end
        rst_n = 1'b1;

        send_single(0, 8'h55, "8n1_55");
        send_single(1, 8'h07, "8e1_07");
        send_single(2, 8'h07, "8o1_07");
        send_single(3, 8'hFF, "7o2_ff");

        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_burst("burst_01_05");

        // Simultaneous push and pop at the final stop tick with two entries queued.
        @(negedge clk); din = 8'h11; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); din = 8'h22;
        @(posedge clk);
        @(negedge clk); din = 8'h33;
        @(posedge clk);
        @(negedge clk); vld[0] = 1'b0;
        check("pushpop level_before", 64'(lvl[0]), 64'd2);
        repeat (38) @(negedge clk);
        check("pushpop pre_edge_state", {60'd0, bsy[0], lvl[0]}, {60'd0, 1'b1, 3'd2});
        din    = 8'h44;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        check("pushpop level_after", 64'(lvl[0]), 64'd2);
        for (int c = 0; c < 200 && !(bsy[0] === 1'b0 && lvl[0] === 3'd0); c++) @(negedge clk);
        check("pushpop drained", {60'd0, bsy[0], lvl[0]}, 64'd0);

        // Reset mid-DATA of 0xA5 with two bytes queued behind it.
        @(negedge clk); din = 8'hA5; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); din = 8'h3C;
        @(posedge clk);
        @(negedge clk); din = 8'hC3;
        @(posedge clk);
        @(negedge clk); vld[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset state", 64'({tx[0], bsy[0], lvl[0], rdy[0]}), 64'(6'b1_0_000_1));
        rst_n     = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || bsy[0] !== 1'b0 || lvl[0] !== 3'd0) quiet_bad++;
        end
        check("midframe_reset no_residual", 64'(quiet_bad), 64'd0);
        send_single(0, 8'($urandom), "post_reset_rand");

        for (int g = 0; g < NDUT; g++) begin
            for (int r = 0; r < 2; r++) begin
                send_single(g, 8'($urandom), $sformatf("rand dut%0d #%0d", g, r));
            end
        end

        bq.delete();
        for (int i = 0; i < 7; i++) bq.push_back(8'($urandom));
        run_burst("burst_rand7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
